// File: rtl/myproject_mac_pipe.sv
// Pipelined signed MAC: NUM_STAGE product registers, ACC_LEN-beat accumulation, rounded/narrowed result.
// Optional clamp-to-DOUT range plus ovf flag when MYPROJECT_MAC_SATURATE_EN is defined.
module myproject_mac_pipe #(
  parameter int DIN0_WIDTH = 16,
  parameter int DIN1_WIDTH = 15,
  parameter int ACC_WIDTH  = 40,
  parameter int DOUT_WIDTH = 16,
  parameter int FRAC_SHIFT = 10,
  parameter int NUM_STAGE  = 2,
  parameter int ACC_LEN    = 9
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst,
  input  logic signed [DIN0_WIDTH-1:0] din0,
  input  logic signed [DIN1_WIDTH-1:0] din1,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic signed [DOUT_WIDTH-1:0] dout,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         busy
`ifdef MYPROJECT_MAC_SATURATE_EN
  ,
  output logic                         ovf
`endif
);

  localparam int PROD_WIDTH = DIN0_WIDTH + DIN1_WIDTH;
  localparam int CNT_WIDTH  = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(ACC_LEN - 1);
  localparam logic signed [ACC_WIDTH:0] RND_BIAS =
    (FRAC_SHIFT > 0) ? ((ACC_WIDTH+1)'(1) << ((FRAC_SHIFT > 0) ? FRAC_SHIFT - 1 : 0)) : '0;
`ifdef MYPROJECT_MAC_SATURATE_EN
  localparam logic signed [ACC_WIDTH:0] SAT_MAX =
    {{(ACC_WIDTH-DOUT_WIDTH+2){1'b0}}, {(DOUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] SAT_MIN = ~SAT_MAX;
`endif

  logic                         en;
  logic signed [PROD_WIDTH-1:0] prod_full;
  logic signed [ACC_WIDTH-1:0]  prod_ext;
  logic signed [ACC_WIDTH-1:0]  pipe_prod;
  logic                         pipe_vld;
  logic                         pipe_busy;

  // One enable stalls the whole engine whenever a result is waiting unaccepted.
  assign en        = !out_valid || out_ready;
  assign in_ready  = en;
  assign prod_full = PROD_WIDTH'(din0) * PROD_WIDTH'(din1);
  assign prod_ext  = ACC_WIDTH'(prod_full);

  generate
    if (NUM_STAGE == 0) begin : g_no_pipe
      assign pipe_prod = prod_ext;
      assign pipe_vld  = in_valid;
      assign pipe_busy = 1'b0;
    end else begin : g_pipe
      logic [NUM_STAGE-1:0]        stg_vld;
      logic signed [ACC_WIDTH-1:0] stg_prod [NUM_STAGE];

      always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
          stg_vld <= '0;
          for (int i = 0; i < NUM_STAGE; i++) stg_prod[i] <= '0;
        end else if (en) begin
          stg_vld[0]  <= in_valid;
          stg_prod[0] <= prod_ext;
          for (int i = 1; i < NUM_STAGE; i++) begin
            stg_vld[i]  <= stg_vld[i-1];
            stg_prod[i] <= stg_prod[i-1];
          end
        end
      end

      assign pipe_prod = stg_prod[NUM_STAGE-1];
      assign pipe_vld  = stg_vld[NUM_STAGE-1];
      assign pipe_busy = |stg_vld;
    end
  endgenerate

  logic [CNT_WIDTH-1:0]        count;
  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH-1:0] acc_next;
  logic signed [ACC_WIDTH:0]   rnd_sum;
  logic signed [ACC_WIDTH:0]   shifted;
  logic signed [DOUT_WIDTH-1:0] res;
  logic                        acc_upd;
  logic                        acc_last;
`ifdef MYPROJECT_MAC_SATURATE_EN
  logic                        res_ovf;
`endif

  always_comb begin
    acc_upd  = en && pipe_vld;
    acc_last = (count == CNT_LAST);
    acc_next = (count == '0) ? pipe_prod : acc + pipe_prod;
    // One guard bit so the rounding bias can never wrap the sum.
    rnd_sum  = $signed({acc_next[ACC_WIDTH-1], acc_next}) + RND_BIAS;
    shifted  = rnd_sum >>> FRAC_SHIFT;
`ifdef MYPROJECT_MAC_SATURATE_EN
    res_ovf = 1'b0;
    res     = DOUT_WIDTH'(shifted);
    if (shifted > SAT_MAX) begin
      res     = DOUT_WIDTH'(SAT_MAX);
      res_ovf = 1'b1;
    end else if (shifted < SAT_MIN) begin
      res     = DOUT_WIDTH'(SAT_MIN);
      res_ovf = 1'b1;
    end
`else
    res = DOUT_WIDTH'(shifted);
`endif
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      count     <= '0;
      acc       <= '0;
      dout      <= '0;
      out_valid <= 1'b0;
`ifdef MYPROJECT_MAC_SATURATE_EN
      ovf       <= 1'b0;
`endif
    end else begin
      if (acc_upd) begin
        acc <= acc_next;
        if (acc_last) count <= '0;
        else          count <= count + CNT_WIDTH'(1);
      end
      if (acc_upd && acc_last) begin
        dout      <= res;
        out_valid <= 1'b1;
`ifdef MYPROJECT_MAC_SATURATE_EN
        ovf       <= res_ovf;
`endif
      end else if (en) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign busy = pipe_busy || (count != '0);

endmodule

// File: tb/tb_myproject_mac_pipe.sv
// Bench for myproject_mac_pipe: default instance plus an ACC_LEN=1/NUM_STAGE=0 instance,
// both checked against a beat-level arithmetic model of the group sums.
module tb_myproject_mac_pipe;

  localparam int F = 10;

  logic ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  logic               ap_rst;
  logic signed [15:0] din0;
  logic signed [14:0] din1;
  logic               in_valid, out_ready;
  logic               in_ready, out_valid, busy;
  logic signed [15:0] dout;
  logic               in_ready1, out_valid1, busy1;
  logic signed [15:0] dout1;
`ifdef MYPROJECT_MAC_SATURATE_EN
  logic               ovf, ovf1;
`endif

  myproject_mac_pipe u_dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .din0(din0), .din1(din1),
    .in_valid(in_valid), .in_ready(in_ready), .dout(dout),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
`ifdef MYPROJECT_MAC_SATURATE_EN
    , .ovf(ovf)
`endif
  );

  myproject_mac_pipe #(.NUM_STAGE(0), .ACC_LEN(1)) u_len1 (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .din0(din0), .din1(din1),
    .in_valid(in_valid), .in_ready(in_ready1), .dout(dout1),
    .out_valid(out_valid1), .out_ready(out_ready), .busy(busy1)
`ifdef MYPROJECT_MAC_SATURATE_EN
    , .ovf(ovf1)
`endif
  );

  int vectors = 0;
  int miscompares = 0;

  longint sum0;
  int     cnt0;
  longint q0[$], q1[$];
`ifdef MYPROJECT_MAC_SATURATE_EN
  bit     qo0[$], qo1[$];
`endif
  longint last0, last1;
  bit     hold0, hold1;
  logic signed [15:0] hd0, hd1;
  logic signed [15:0] fa[64];
  logic signed [14:0] fb[64];

  function automatic longint wrap_acc(longint s);
    logic [39:0] t;
    t = s[39:0];
    return $signed(t);
  endfunction

  function automatic longint rounded(longint s);
    return (s + (longint'(1) <<< (F - 1))) >>> F;
  endfunction

  function automatic bit clamps(longint r);
    return (r > 32767) || (r < -32768);
  endfunction

  function automatic longint narrow(longint r);
`ifdef MYPROJECT_MAC_SATURATE_EN
    if (r > 32767) return 32767;
    if (r < -32768) return -32768;
    return r;
`else
    logic [15:0] t;
    t = r[15:0];
    return $signed(t);
`endif
  endfunction

  task automatic chk(input string tag, input longint got, input longint exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock cycle: drive at negedge, sample 1ns later, update the model for the coming edge.
  task automatic cyc(input bit v, input logic signed [15:0] a, input logic signed [14:0] b,
                     input bit ordy, input bit rst);
    longint p, e;
    @(negedge ap_clk);
    ap_rst = rst; in_valid = v; din0 = a; din1 = b; out_ready = ordy;
    #1;
    if (hold0) begin
      chk("hold0_vld", out_valid, 1);
      chk("hold0_dout", dout, hd0);
    end
    if (hold1) begin
      chk("hold1_vld", out_valid1, 1);
      chk("hold1_dout", dout1, hd1);
    end
    if (rst) begin
      sum0 = 0; cnt0 = 0;
      q0.delete(); q1.delete();
`ifdef MYPROJECT_MAC_SATURATE_EN
      qo0.delete(); qo1.delete();
`endif
    end else begin
      if (out_valid && out_ready) begin
        chk("res0_pending", q0.size() > 0, 1);
        if (q0.size() > 0) begin
          e = q0.pop_front();
          chk("res0_dout", dout, e);
`ifdef MYPROJECT_MAC_SATURATE_EN
          chk("res0_ovf", ovf, qo0.pop_front());
`endif
          last0 = dout;
        end
      end
      if (out_valid1 && out_ready) begin
        chk("res1_pending", q1.size() > 0, 1);
        if (q1.size() > 0) begin
          e = q1.pop_front();
          chk("res1_dout", dout1, e);
`ifdef MYPROJECT_MAC_SATURATE_EN
          chk("res1_ovf", ovf1, qo1.pop_front());
`endif
          last1 = dout1;
        end
      end
      p = longint'(a) * longint'(b);
      if (v && in_ready) begin
        sum0 = wrap_acc(sum0 + p);
        cnt0++;
        if (cnt0 == 9) begin
          q0.push_back(narrow(rounded(sum0)));
`ifdef MYPROJECT_MAC_SATURATE_EN
          qo0.push_back(clamps(rounded(sum0)));
`endif
          sum0 = 0; cnt0 = 0;
        end
      end
      if (v && in_ready1) begin
        q1.push_back(narrow(rounded(p)));
`ifdef MYPROJECT_MAC_SATURATE_EN
        qo1.push_back(clamps(rounded(p)));
`endif
      end
    end
    hold0 = !rst && out_valid && !ordy;
    hold1 = !rst && out_valid1 && !ordy;
    hd0 = dout; hd1 = dout1;
  endtask

  // Present fa/fb beats until n are accepted; optionally stall the output side
  // from the start until the first result, then stall_len more cycles.
  task automatic feed(input int n, input int stall_len);
    int idx = 0;
    int stall = 0;
    bit started = 0;
    bit ordy;
    for (int c = 0; c < 400 && idx < n; c++) begin
      ordy = (stall_len == 0) || (started && stall == 0);
      cyc(1'b1, fa[idx], fb[idx], ordy, 1'b0);
      if (in_ready) idx++;
      if (!ordy && out_valid) chk("bp_in_ready", in_ready, 0);
      if (stall > 0) stall--;
      else if (!started && stall_len > 0 && out_valid) begin
        started = 1; stall = stall_len;
      end
    end
    chk("feed_beats", idx, n);
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && (q0.size() > 0 || q1.size() > 0 || out_valid || out_valid1); i++)
      cyc(1'b0, 16'sd0, 15'sd0, 1'b1, 1'b0);
    chk("drain_q0", q0.size(), 0);
    chk("drain_q1", q1.size(), 0);
  endtask

  task automatic set_group(input logic signed [15:0] a0, input logic signed [14:0] b0,
                           input logic signed [15:0] ar, input logic signed [14:0] br);
    fa[0] = a0; fb[0] = b0;
    for (int i = 1; i < 9; i++) begin fa[i] = ar; fb[i] = br; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ap_rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; din0 = '0; din1 = '0;
    sum0 = 0; cnt0 = 0; hold0 = 0; hold1 = 0; last0 = 0; last1 = 0;
    cyc(1'b0, 16'sd0, 15'sd0, 1'b1, 1'b1);
    cyc(1'b0, 16'sd0, 15'sd0, 1'b1, 1'b1);
    cyc(1'b0, 16'sd0, 15'sd0, 1'b1, 1'b0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_dout", dout, 0);

    // Basic group and latency: result visible exactly on the third cycle after the last beat.
    for (int i = 0; i < 9; i++) cyc(1'b1, 16'sd1024, 15'sd1024, 1'b1, 1'b0);
    chk("basic_busy", busy, 1);
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, 16'sd0, 15'sd0, 1'b1, 1'b0);
      chk("basic_lat", out_valid, (k == 2));
      if (k == 2) chk("basic_dout", dout, 9216);
    end
    chk("basic_idle_busy", busy, 0);
    drain();

    set_group(-16'sd1024, 15'sd512, -16'sd1024, 15'sd512);
    feed(9, 0); drain();
    chk("neg_dout", last0, -4608);

    set_group(16'sd512, 15'sd1, 16'sd0, 15'sd0);
    feed(9, 0); drain();
    chk("round_up_dout", last0, 1);

    set_group(-16'sd512, 15'sd1, 16'sd0, 15'sd0);
    feed(9, 0); drain();
    chk("round_half_dout", last0, 0);

    set_group(16'sd32767, 15'sd16383, 16'sd32767, 15'sd16383);
    feed(9, 0); drain();
`ifdef MYPROJECT_MAC_SATURATE_EN
    chk("sat_dout", last0, 32767);
`else
    chk("wrap_dout", last0, -432);
`endif

    // Three back-to-back groups with output held off for 10 cycles after the first result.
    for (int i = 0; i < 27; i++) begin
      fa[i] = 16'($urandom);
      fb[i] = 15'($urandom);
    end
    feed(27, 10); drain();

    // Single-beat instance: a result completes every cycle while the previous one pops.
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 16'(1024 * (i + 1)), 15'sd1, 1'b1, 1'b0);
      if (i > 0) begin
        chk("b2b_vld1", out_valid1, 1);
        chk("b2b_dout1", dout1, i);
      end
    end

    // Reset after 5 beats of a group (beats still in the pipe) discards the partial sum.
    cyc(1'b1, 16'sd3000, 15'sd3000, 1'b1, 1'b1);
    cyc(1'b0, 16'sd0, 15'sd0, 1'b1, 1'b0);
    chk("post_rst_out_valid", out_valid, 0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_out_valid1", out_valid1, 0);
    set_group(16'sd1024, 15'sd1024, 16'sd1024, 15'sd1024);
    feed(9, 0); drain();
    chk("post_rst_dout", last0, 9216);

    // Random traffic with random backpressure.
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 3) != 0, 16'($urandom), 15'($urandom),
          $urandom_range(0, 2) != 0, 1'b0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/myproject_mac_pipe.md
Name: myproject_mac_pipe

Overview:
- Pipelined, parametrised signed multiply-accumulate engine for the pruned-CNN datapath.
- Generalises the combinational signed multiplier in three ways: configurable multiplier pipeline depth, accumulation over ACC_LEN products (e.g. one 3x3 kernel window), and fixed-point rounding/narrowing of the result.
- Sits between the weight/feature fetch logic and the activation stage.
- Uses valid/ready handshakes on both sides so it can be stalled by downstream.

Parameters:
- DIN0_WIDTH, 16, signed feature operand width
- DIN1_WIDTH, 15, signed weight operand width
- ACC_WIDTH, 40, accumulator width; must be >= DIN0_WIDTH+DIN1_WIDTH+clog2(ACC_LEN)
- DOUT_WIDTH, 16, signed output width
- FRAC_SHIFT, 10, right shift applied to the accumulator at output; 0 = no shift, no rounding
- NUM_STAGE, 2, product register stages between the multiplier and the accumulator (0 allowed)
- ACC_LEN, 9, products summed per output result (>=1)

Ports:
- ap_clk  in  1  clock; all state updates on rising edge
- ap_rst  in  1  synchronous, active-high reset
- din0  in  DIN0_WIDTH  signed feature operand
- din1  in  DIN1_WIDTH  signed weight operand
- in_valid  in  1  operand pair valid
- in_ready  out  1  block accepts operands this cycle
- dout  out  DOUT_WIDTH  signed rounded result
- out_valid  out  1  dout valid
- out_ready  in  1  downstream accepts dout
- busy  out  1  any beat in flight in the product pipe, or count != 0

Behaviour:
- Global enable: en = !out_valid || out_ready. in_ready = en (combinational). A beat is accepted when in_valid && in_ready.
- Product: signed din0 * signed din1, full width DIN0_WIDTH+DIN1_WIDTH, sign-extended to ACC_WIDTH.
- Product pipe: the product plus a valid bit pass through NUM_STAGE registers, all advancing only when en=1.
  - Bubbles (in_valid=0) propagate as invalid.
  - When en=0, every register holds its value.
- Accumulate stage: updates only when en=1 and the pipe output is valid.
  - If count==0: acc_next = prod; otherwise acc_next = acc + prod. Arithmetic wraps modulo 2^ACC_WIDTH.
  - If count==ACC_LEN-1: count <- 0 and dout <- convert(acc_next); out_valid <- 1.
  - Otherwise: count <- count+1.
- Convert: r = (acc_next + (FRAC_SHIFT>0 ? 2^(FRAC_SHIFT-1) : 0)) >>> FRAC_SHIFT (arithmetic shift, round half toward +inf); then narrow to DOUT_WIDTH per Optional Feature.
- Latency: the last beat of a group accepted at cycle T gives out_valid=1 at cycle T+NUM_STAGE+1.
- Throughput: 1 beat/cycle with no backpressure. Consecutive groups need no gap.
- Output register rules:
  - out_valid clears on out_ready=1 when no new result is written that cycle.
  - If out_ready=1 and a new result completes in the same cycle, out_valid stays 1 and dout takes the new value.
  - dout is stable while out_valid && !out_ready.
- Reset (any cycle, including mid-group or mid-stall), effective next edge:
  - out_valid=0, dout=0, count=0, acc=0.
  - All pipe valid bits 0; busy=0.
  - Partial sums are discarded. in_ready=1 in the cycle after reset.
- ACC_LEN=1: every beat produces a result.
- NUM_STAGE=0: the product feeds the accumulator combinationally; latency = 1 cycle.

Optional Feature:
- Macro: MYPROJECT_MAC_SATURATE_EN.
- Defined: r is clamped to [-(2^(DOUT_WIDTH-1)), 2^(DOUT_WIDTH-1)-1] before output. Adds output ovf (1 bit), registered with dout, set when a clamp occurred; reset 0.
- Undefined: dout = r[DOUT_WIDTH-1:0] (two's-complement wrap). No ovf port.

Test Plan:
- Basic: defaults, 9 beats din0=1024, din1=1024, out_ready=1 -> one result, dout=9216, out_valid high exactly 3 cycles after the 9th beat, for 1 cycle.
- Sign/rounding:
  - 9 beats din0=-1024, din1=512 -> dout=-4608.
  - Group {512*1, then 8x 0} -> dout=1.
  - Group {-512*1, then 8x 0} -> dout=0.
- Saturation: 9 beats din0=32767, din1=16383.
  - With macro -> dout=32767, ovf=1.
  - Without macro -> dout equals the low 16 bits of the rounded sum.
- Backpressure: 3 back-to-back groups with out_ready held 0 for 10 cycles after the first result -> in_ready drops, dout holds the first value, no beat lost; all 3 results appear in order once out_ready=1.
- Simultaneous: a group completes in the same cycle out_ready=1 pops the previous result -> out_valid stays 1 and dout updates; results arrive back-to-back with no gap.
- Reset: assert ap_rst after 5 beats of a group, then send a fresh 9-beat group -> the first result excludes the pre-reset beats; out_valid=0 and busy=0 in the cycle after reset.
